// File: rtl/pipeline_debug_pkg.sv
// Shared definitions for the pipeline debug controller: command codes, FSM states, dump sections.
package pipeline_debug_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_DUMP  = 8'h44;
  localparam logic [7:0] CMD_CLEAR = 8'h43;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_FETCH,
    ST_SEND
  } state_t;

  typedef enum logic [1:0] {
    SEC_PC,
    SEC_CYC,
    SEC_REG,
    SEC_MEM
  } section_t;

endpackage

// File: rtl/pipeline_debug_ctrl_word_tx_serializer.sv
// Word-to-byte serializer: emits a loaded word MSB byte first over a valid/ready stream.
module word_tx_serializer #(
  parameter int unsigned NB_REG  = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_REG-1:0]  i_word,
  output logic [NB_BYTE-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_done
);

  localparam int unsigned N_BYTES = NB_REG / NB_BYTE;
  localparam int unsigned NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [NB_REG-1:0] shift;
  logic [NB_CNT-1:0] cnt;
  logic              valid;
  logic              xfer;
  logic              last;

  assign xfer    = valid & i_ready;
  assign last    = (cnt == NB_CNT'(N_BYTES - 1));
  assign o_done  = xfer & last;
  assign o_data  = shift[NB_REG-1 -: NB_BYTE];
  assign o_valid = valid;

  // Load a new word or shift out one byte per accepted transfer; data holds while stalled.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (i_load) begin
      shift <= i_word;
      cnt   <= '0;
      valid <= 1'b1;
    end else if (xfer) begin
      if (last) begin
        valid <= 1'b0;
      end else begin
        shift <= shift << NB_BYTE;
        cnt   <= cnt + NB_CNT'(1);
      end
    end
  end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Debug/run controller for the 5-stage pipeline: command decode, run/step, cycle count, state dump.
module pipeline_debug_ctrl
  import pipeline_debug_pkg::*;
#(
  parameter int unsigned NB_REG          = 32,
  parameter int unsigned NB_REG_ADDR     = 5,
  parameter int unsigned REGFILE_DEPTH   = 32,
  parameter int unsigned NB_DATA_ADDR    = 10,
  parameter int unsigned DATA_DUMP_WORDS = 16,
  parameter int unsigned NB_BYTE         = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_BYTE-1:0]      i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  output logic [NB_BYTE-1:0]      o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_pipe_valid,
  output logic                    o_pipe_reset,
  input  logic                    i_halt,
  input  logic [NB_REG-1:0]       i_pc,
  output logic [NB_REG_ADDR-1:0]  o_reg_addr,
  input  logic [NB_REG-1:0]       i_reg_data,
  output logic [NB_DATA_ADDR-1:0] o_mem_addr,
  input  logic [NB_REG-1:0]       i_mem_data,
  output logic                    o_busy
);

  localparam logic [NB_REG_ADDR-1:0]  REG_LAST = NB_REG_ADDR'(REGFILE_DEPTH - 1);
  localparam logic [NB_DATA_ADDR-1:0] MEM_LAST = NB_DATA_ADDR'(DATA_DUMP_WORDS - 1);

  state_t                  state, state_next;
  section_t                section, section_next;
  logic                    ser_load;
  logic [NB_REG-1:0]       ser_word;
  logic                    ser_done;
  logic                    cmd_clear;
  logic                    dump_entry;
  logic                    halted;
  logic [NB_REG-1:0]       cycle_count;
  logic                    word_last;
  logic                    rx_ready, busy, pipe_valid, pipe_reset;
  logic [NB_REG_ADDR-1:0]  reg_addr;
  logic [NB_DATA_ADDR-1:0] mem_addr;

  // Next-state, section sequencing and serializer load selection.
  always_comb begin
    state_next   = state;
    section_next = section;
    ser_load     = 1'b0;
    ser_word     = '0;
    cmd_clear    = 1'b0;
    dump_entry   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == NB_BYTE'(CMD_RUN)) begin
            if (!halted) state_next = ST_RUN;
          end else if (i_rx_data == NB_BYTE'(CMD_STEP)) begin
            if (!halted) state_next = ST_STEP;
          end else if (i_rx_data == NB_BYTE'(CMD_DUMP)) begin
            dump_entry = 1'b1;
          end else if (i_rx_data == NB_BYTE'(CMD_CLEAR)) begin
            cmd_clear = 1'b1;
          end
        end
      end
      ST_RUN:  if (i_halt) dump_entry = 1'b1;
      ST_STEP: dump_entry = 1'b1;
      ST_FETCH: begin
        ser_load   = 1'b1;
        ser_word   = (section == SEC_REG) ? i_reg_data : i_mem_data;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (ser_done) begin
          case (section)
            SEC_PC: begin
              ser_load     = 1'b1;
              ser_word     = cycle_count;
              section_next = SEC_CYC;
            end
            SEC_CYC: begin
              section_next = SEC_REG;
              state_next   = ST_FETCH;
            end
            SEC_REG: begin
              if (word_last) section_next = SEC_MEM;
              state_next = ST_FETCH;
            end
            default: state_next = word_last ? ST_IDLE : ST_FETCH;
          endcase
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Dump entry latches the PC straight into the serializer.
    if (dump_entry) begin
      state_next   = ST_SEND;
      section_next = SEC_PC;
      ser_load     = 1'b1;
      ser_word     = i_pc;
    end
  end

  // State register and registered control outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      section    <= SEC_PC;
      rx_ready   <= 1'b1;
      busy       <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_reset <= 1'b0;
    end else begin
      state      <= state_next;
      section    <= section_next;
      rx_ready   <= (state_next == ST_IDLE);
      busy       <= (state_next != ST_IDLE);
      pipe_valid <= (state_next == ST_RUN) || (state_next == ST_STEP);
      pipe_reset <= cmd_clear;
    end
  end

  // Cycle counter, halt flag and dump address walk (next address is prepared at each fetch).
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cycle_count <= '0;
      halted      <= 1'b0;
      reg_addr    <= '0;
      mem_addr    <= '0;
      word_last   <= 1'b0;
    end else begin
      if (cmd_clear) begin
        cycle_count <= '0;
        halted      <= 1'b0;
      end else if (pipe_valid) begin
        if (cycle_count != '1) cycle_count <= cycle_count + NB_REG'(1);
        if (i_halt) halted <= 1'b1;
      end
      if (dump_entry) begin
        reg_addr  <= '0;
        mem_addr  <= '0;
        word_last <= 1'b0;
      end else if (state == ST_FETCH) begin
        if (section == SEC_REG) begin
          word_last <= (reg_addr == REG_LAST);
          if (reg_addr != REG_LAST) reg_addr <= reg_addr + NB_REG_ADDR'(1);
        end else begin
          word_last <= (mem_addr == MEM_LAST);
          if (mem_addr != MEM_LAST) mem_addr <= mem_addr + NB_DATA_ADDR'(1);
        end
      end
    end
  end

  word_tx_serializer #(
    .NB_REG  (NB_REG),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (ser_load),
    .i_word  (ser_word),
    .o_data  (o_tx_data),
    .o_valid (o_tx_valid),
    .i_ready (i_tx_ready),
    .o_done  (ser_done)
  );

  assign o_rx_ready   = rx_ready;
  assign o_busy       = busy;
  assign o_pipe_valid = pipe_valid;
  assign o_pipe_reset = pipe_reset;
  assign o_reg_addr   = reg_addr;
  assign o_mem_addr   = mem_addr;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: step, run-to-halt, stalled dump, clear, reset abort.
module tb_pipeline_debug_ctrl;

  localparam int TOTAL = 200;

  logic        i_clock;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_pipe_valid;
  logic        o_pipe_reset;
  logic        i_halt;
  logic [31:0] i_pc;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data;
  logic [9:0]  o_mem_addr;
  logic [31:0] i_mem_data;
  logic        o_busy;

  int total_n;
  int bad_n;
  int pv_cnt;
  int pr_cnt;
  int halt_at;
  int stall_err;
  bit stall_pend;
  logic [7:0] stall_data;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  pipeline_debug_ctrl dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_pipe_valid (o_pipe_valid),
    .o_pipe_reset (o_pipe_reset),
    .i_halt       (i_halt),
    .i_pc         (i_pc),
    .o_reg_addr   (o_reg_addr),
    .i_reg_data   (i_reg_data),
    .o_mem_addr   (o_mem_addr),
    .i_mem_data   (i_mem_data),
    .o_busy       (o_busy)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Register file Rn=n and data memory MEM[k]=0xA5000000+k, one-cycle read latency.
  always @(posedge i_clock) begin
    i_reg_data <= 32'(o_reg_addr);
    i_mem_data <= 32'hA500_0000 + 32'(o_mem_addr);
  end

  function automatic void push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endfunction

  function automatic void build_exp(input logic [31:0] pc, input logic [31:0] cnt);
    exp_q.delete();
    push_word(pc);
    push_word(cnt);
    for (int r = 0; r < 32; r++) push_word(32'(r));
    for (int k = 0; k < 16; k++) push_word(32'hA500_0000 + 32'(k));
  endfunction

  function automatic int seq_errs();
    int n;
    n = 0;
    for (int i = 0; i < TOTAL; i++) begin
      if (i >= got.size()) n++;
      else if (got[i] !== exp_q[i]) n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] got_word(input int idx);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) if (idx + b < got.size()) w = {w[23:0], got[idx + b]};
    return w;
  endfunction

  // One clock cycle seen from the negedge: drive ready/halt, observe, then advance.
  task automatic cycle(input bit rdy);
    i_tx_ready = rdy;
    if (o_pipe_valid) begin
      pv_cnt++;
      i_halt = (pv_cnt == halt_at);
    end else begin
      i_halt = 1'b0;
    end
    if (o_pipe_reset) pr_cnt++;
    if (stall_pend && (o_tx_valid !== 1'b1 || o_tx_data !== stall_data)) stall_err++;
    if (o_tx_valid && rdy) got.push_back(o_tx_data);
    stall_pend = o_tx_valid && !rdy;
    stall_data = o_tx_data;
    @(negedge i_clock);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    cycle(1'b1);
    i_rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    i_reset    = 1'b0;
    stall_pend = 1'b0;
    cycle(1'b0);
  endtask

  task automatic run_dump(input bit stall, output bit timeout, output int lag);
    int n;
    int full_at;
    timeout = 1'b1;
    full_at = -1;
    lag     = -1;
    n       = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle(stall ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
      if (full_at < 0 && got.size() == TOTAL) full_at = n;
      if (!o_busy) begin
        timeout = 1'b0;
        break;
      end
    end
    if (full_at >= 0) lag = n - full_at;
  endtask

  task automatic test_reset();
    do_reset();
    total_n++; if (o_rx_ready !== 1'b1) begin bad_n++; $display("FAIL reset_rx_ready: got %b want 1", o_rx_ready); end
    total_n++; if (o_pipe_valid !== 1'b0) begin bad_n++; $display("FAIL reset_pipe_valid: got %b want 0", o_pipe_valid); end
    total_n++; if (o_tx_valid !== 1'b0) begin bad_n++; $display("FAIL reset_tx_valid: got %b want 0", o_tx_valid); end
    total_n++; if (o_pipe_reset !== 1'b0) begin bad_n++; $display("FAIL reset_pipe_reset: got %b want 0", o_pipe_reset); end
    total_n++; if (o_busy !== 1'b0) begin bad_n++; $display("FAIL reset_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_step();
    bit to;
    int lag;
    int e8;
    logic [7:0] ref8 [8];
    ref8 = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01};
    i_pc = 32'h0000_0004;
    halt_at = 0;
    pv_cnt = 0;
    got.delete();
    send_cmd(8'h53);
    total_n++; if (o_busy !== 1'b1) begin bad_n++; $display("FAIL step_accept: busy got %b want 1", o_busy); end
    run_dump(1'b0, to, lag);
    total_n++; if (to !== 1'b0) begin bad_n++; $display("FAIL step_timeout: dump did not finish"); end
    total_n++; if (pv_cnt !== 1) begin bad_n++; $display("FAIL step_pipe_valid: got %0d cycles want 1", pv_cnt); end
    total_n++; if (got.size() !== TOTAL) begin bad_n++; $display("FAIL step_bytes: got %0d want %0d", got.size(), TOTAL); end
    e8 = 0;
    for (int i = 0; i < 8; i++) if (i >= got.size() || got[i] !== ref8[i]) e8++;
    total_n++; if (e8 !== 0) begin bad_n++; $display("FAIL step_first8: %0d wrong bytes, got %h %h want 00000004 00000001", e8, got_word(0), got_word(4)); end
    build_exp(32'h0000_0004, 32'd1);
    total_n++; if (seq_errs() !== 0) begin bad_n++; $display("FAIL step_sequence: %0d wrong bytes want 0", seq_errs()); end
    total_n++; if (lag !== 0) begin bad_n++; $display("FAIL step_idle_after_last: got lag %0d want 0", lag); end
  endtask

  task automatic test_run_halt();
    bit to;
    int lag;
    do_reset();
    i_pc = 32'h0000_0040;
    halt_at = 10;
    pv_cnt = 0;
    got.delete();
    send_cmd(8'h52);
    run_dump(1'b0, to, lag);
    halt_at = 0;
    total_n++; if (to !== 1'b0) begin bad_n++; $display("FAIL run_timeout: dump did not finish"); end
    total_n++; if (pv_cnt !== 10) begin bad_n++; $display("FAIL run_pipe_valid: got %0d cycles want 10", pv_cnt); end
    total_n++; if (got_word(4) !== 32'h0000_000A) begin bad_n++; $display("FAIL run_cycle_count: got %h want 0000000a", got_word(4)); end
    build_exp(32'h0000_0040, 32'd10);
    total_n++; if (seq_errs() !== 0) begin bad_n++; $display("FAIL run_sequence: %0d wrong bytes want 0", seq_errs()); end
  endtask

  task automatic test_halted_clear();
    bit to;
    int lag;
    pv_cnt = 0;
    send_cmd(8'h52);
    cycle(1'b1);
    send_cmd(8'h53);
    cycle(1'b1);
    cycle(1'b1);
    total_n++; if (pv_cnt !== 0) begin bad_n++; $display("FAIL halted_ignore: got %0d valid cycles want 0", pv_cnt); end
    total_n++; if (o_busy !== 1'b0 || o_rx_ready !== 1'b1) begin bad_n++; $display("FAIL halted_idle: busy %b rx_ready %b want 0 1", o_busy, o_rx_ready); end
    pr_cnt = 0;
    send_cmd(8'h43);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    total_n++; if (pr_cnt !== 1) begin bad_n++; $display("FAIL clear_pulse: got %0d cycles want 1", pr_cnt); end
    i_pc = 32'h0000_0040;
    pv_cnt = 0;
    got.delete();
    send_cmd(8'h53);
    run_dump(1'b0, to, lag);
    total_n++; if (pv_cnt !== 1) begin bad_n++; $display("FAIL clear_step: got %0d valid cycles want 1", pv_cnt); end
    total_n++; if (got_word(4) !== 32'd1) begin bad_n++; $display("FAIL clear_count: got %h want 00000001", got_word(4)); end
  endtask

  task automatic test_stalls();
    bit to;
    int lag;
    do_reset();
    i_pc = 32'h1234_5678;
    got.delete();
    stall_err = 0;
    send_cmd(8'h44);
    run_dump(1'b1, to, lag);
    total_n++; if (to !== 1'b0) begin bad_n++; $display("FAIL stall_timeout: dump did not finish"); end
    total_n++; if (got.size() !== TOTAL) begin bad_n++; $display("FAIL stall_bytes: got %0d want %0d", got.size(), TOTAL); end
    build_exp(32'h1234_5678, 32'd0);
    total_n++; if (seq_errs() !== 0) begin bad_n++; $display("FAIL stall_sequence: %0d wrong bytes want 0", seq_errs()); end
    total_n++; if (stall_err !== 0) begin bad_n++; $display("FAIL stall_hold: %0d unstable stall cycles want 0", stall_err); end
  endtask

  task automatic test_reset_mid_dump();
    bit to;
    int lag;
    do_reset();
    i_pc = 32'h0000_0077;
    got.delete();
    send_cmd(8'h44);
    for (int i = 0; i < 500; i++) begin
      cycle(1'b1);
      if (got.size() >= 30) break;
    end
    total_n++; if (got.size() !== 30) begin bad_n++; $display("FAIL abort_reach_r5: got %0d bytes want 30", got.size()); end
    i_reset = 1'b1;
    i_tx_ready = 1'b0;
    @(negedge i_clock);
    i_reset = 1'b0;
    stall_pend = 1'b0;
    total_n++; if (o_tx_valid !== 1'b0) begin bad_n++; $display("FAIL abort_tx_valid: got %b want 0", o_tx_valid); end
    total_n++; if (o_busy !== 1'b0 || o_rx_ready !== 1'b1) begin bad_n++; $display("FAIL abort_idle: busy %b rx_ready %b want 0 1", o_busy, o_rx_ready); end
    pv_cnt = 0;
    send_cmd(8'h00);
    cycle(1'b1);
    total_n++; if (o_busy !== 1'b0 || o_tx_valid !== 1'b0 || pv_cnt !== 0 || o_rx_ready !== 1'b1) begin
      bad_n++; $display("FAIL unknown_cmd: busy %b tx_valid %b valid cycles %0d rx_ready %b want 0 0 0 1", o_busy, o_tx_valid, pv_cnt, o_rx_ready);
    end
    got.delete();
    send_cmd(8'h44);
    run_dump(1'b0, to, lag);
    total_n++; if (got_word(4) !== 32'd0) begin bad_n++; $display("FAIL abort_count: got %h want 00000000", got_word(4)); end
    build_exp(32'h0000_0077, 32'd0);
    total_n++; if (seq_errs() !== 0) begin bad_n++; $display("FAIL abort_redump: %0d wrong bytes want 0", seq_errs()); end
  endtask

  initial begin
    total_n = 0;
    bad_n = 0;
    pv_cnt = 0;
    pr_cnt = 0;
    halt_at = 0;
    stall_err = 0;
    stall_pend = 1'b0;
    stall_data = '0;
    i_reset = 1'b1;
    i_rx_data = '0;
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b0;
    i_halt = 1'b0;
    i_pc = '0;
    @(negedge i_clock);
    test_reset();
    test_step();
    test_run_halt();
    test_halted_clear();
    test_stalls();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
